// File: rtl/input_conditioner.sv
// Purpose : synchronize, debounce and edge-detect a raw asynchronous 1-bit input.
// Latency : dout follows a held din change on the (SYNC_STAGES+DEB_CYCLES)th rising edge.
// Backpr. : none; en=0 freezes qualification (FSM, cnt, dout), the synchronizer keeps shifting.
// Ports   : clk, rst (async active-low), din (raw), en (debouncer enable),
//           dout (clean level), rise/fall (one-cycle edge pulses), busy (qualifying).
module input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            dout_nxt;
  logic            rise_nxt;
  logic            fall_nxt;

  // Synchronizer chain: shifts every cycle regardless of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Debouncer state, level and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_STABLE;
      cnt   <= '0;
      dout  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dout  <= dout_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Next-state logic. Pulses are computed alongside the dout update so they
  // appear in the same cycle dout first shows the new level; since dout only
  // ever takes the value of sync when they differ, rise and fall are exclusive.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dout_nxt  = dout;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;

    if (en) begin
      case (state)
        ST_STABLE: begin
          if (sync != dout) begin
            if (DEB_CYCLES == 1) begin
              // Single-cycle qualification: accept immediately.
              dout_nxt = sync;
              rise_nxt = sync;
              fall_nxt = ~sync;
            end else begin
              state_nxt = ST_CHECK;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        ST_CHECK: begin
          if (sync == dout) begin
            // Candidate vanished before qualifying: treat as a glitch.
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            dout_nxt  = sync;
            rise_nxt  = sync;
            fall_nxt  = ~sync;
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign busy = (state == ST_CHECK);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner.
// Main instance uses defaults (2 sync stages, 4 debounce cycles, reset level 0);
// a second instance covers the single-cycle debounce and reset level 1 corner.
module tb_input_conditioner;

  logic clk;
  logic rst;
  logic din;
  logic en;
  logic dout, rise, fall, busy;

  logic din_b;
  logic dout_b, rise_b, fall_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  int n_rise = 0;
  int n_fall = 0;
  int n_both = 0;
  int r0, f0;

  input_conditioner dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .en   (en),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  input_conditioner #(
    .SYNC_STAGES (3),
    .DEB_CYCLES  (1),
    .RST_VAL     (1'b1)
  ) dut_b (
    .clk  (clk),
    .rst  (rst),
    .din  (din_b),
    .en   (en),
    .dout (dout_b),
    .rise (rise_b),
    .fall (fall_b),
    .busy (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor on the main instance, sampled away from the active edge.
  always @(negedge clk) begin
    if (rise) n_rise++;
    if (fall) n_fall++;
    if (rise && fall) n_both++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    din   = 1'b1;
    din_b = 1'b1;
    en    = 1'b1;

    // Reset held for two cycles with din=1.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_dout", dout, 0);
      chk("rst_rise", rise, 0);
      chk("rst_fall", fall, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dout_b", dout_b, 1);
    end

    // Release with din=0 held: nothing changes.
    step();
    rst = 1'b1;
    din = 1'b0;
    r0 = n_rise; f0 = n_fall;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_dout", dout, 0);
      chk("idle_busy", busy, 0);
      chk("idle_dout_b", dout_b, 1);
      chk("idle_busy_b", busy_b, 0);
    end
    chk("idle_rises", n_rise - r0, 0);
    chk("idle_falls", n_fall - f0, 0);

    // Clean rise: 6-edge latency.
    r0 = n_rise; f0 = n_fall;
    din = 1'b1;
    step(); chk("cr_busy_e1", busy, 0);
    step(); chk("cr_busy_e2", busy, 0);
    step(); chk("cr_busy_e3", busy, 1); chk("cr_dout_e3", dout, 0);
    step(); chk("cr_dout_e4", dout, 0);
    step(); chk("cr_dout_e5", dout, 0); chk("cr_rise_e5", rise, 0);
    step(); chk("cr_dout_e6", dout, 1); chk("cr_rise_e6", rise, 1); chk("cr_fall_e6", fall, 0);
    step(); chk("cr_rise_e7", rise, 0); chk("cr_dout_e7", dout, 1); chk("cr_busy_e7", busy, 0);
    chk("cr_rise_count", n_rise - r0, 1);
    chk("cr_fall_count", n_fall - f0, 0);

    // Glitch reject: din low for 3 cycles only.
    r0 = n_rise; f0 = n_fall;
    din = 1'b0;
    step(); step(); step();
    chk("gl_busy_mid", busy, 1);
    din = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("gl_dout", dout, 1);
      chk("gl_fall", fall, 0);
    end
    chk("gl_busy_end", busy, 0);
    chk("gl_fall_count", n_fall - f0, 0);
    chk("gl_rise_count", n_rise - r0, 0);

    // Clean fall.
    r0 = n_rise; f0 = n_fall;
    din = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("cf_dout_pre", dout, 1);
    end
    step(); chk("cf_dout_e6", dout, 0); chk("cf_fall_e6", fall, 1); chk("cf_rise_e6", rise, 0);
    step(); chk("cf_fall_e7", fall, 0); chk("cf_dout_e7", dout, 0);
    chk("cf_fall_count", n_fall - f0, 1);
    chk("cf_rise_count", n_rise - r0, 0);

    // Single-cycle debounce, 3 sync stages: fall on the 4th edge, never busy.
    din_b = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("b_dout_pre", dout_b, 1);
      chk("b_busy", busy_b, 0);
    end
    step(); chk("b_dout_e4", dout_b, 0); chk("b_fall_e4", fall_b, 1); chk("b_rise_e4", rise_b, 0);
    step(); chk("b_fall_e5", fall_b, 0); chk("b_dout_e5", dout_b, 0);

    // Enable freeze at cnt=2.
    r0 = n_rise;
    din = 1'b1;
    step(); step(); step(); step();
    chk("ef_busy_cnt2", busy, 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ef_dout_frz", dout, 0);
      chk("ef_rise_frz", rise, 0);
      chk("ef_busy_frz", busy, 1);
    end
    en = 1'b1;
    step(); chk("ef_dout_r1", dout, 0);
    step(); chk("ef_dout_r2", dout, 1); chk("ef_rise_r2", rise, 1);
    step(); chk("ef_rise_r3", rise, 0);
    chk("ef_rise_count", n_rise - r0, 1);

    // Reset mid-qualification (dout=1, falling candidate at cnt=3).
    din = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rm_busy_pre", busy, 1);
    chk("rm_dout_pre", dout, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rm_dout", dout, 0);
    chk("rm_busy", busy, 0);
    chk("rm_rise", rise, 0);
    chk("rm_fall", fall, 0);
    chk("rm_dout_b", dout_b, 1);
    din = 1'b1;
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("rm_dout_lat", dout, 0);
    end
    step(); chk("rm_dout_e6", dout, 1); chk("rm_rise_e6", rise, 1);

    chk("never_both", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
